// File: rtl/shift_exec_stage.sv
// Registered execution stage around the combinational 16-bit shifters.
// Adds a two-pass rotate-left built from sll and srl.

module Sll16 (
    input  logic [15:0] a_i,
    input  logic [3:0]  shamt_i,
    output logic [15:0] y_o
);
    assign y_o = a_i << shamt_i;
endmodule

module Srl16 (
    input  logic [15:0] a_i,
    input  logic [3:0]  shamt_i,
    output logic [15:0] y_o
);
    assign y_o = a_i >> shamt_i;
endmodule

module Sra16 (
    input  logic [15:0] a_i,
    input  logic [3:0]  shamt_i,
    output logic [15:0] y_o
);
    assign y_o = $signed(a_i) >>> shamt_i;
endmodule

module shift_exec_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [15:0] in_data,
    input  logic [3:0]  in_shamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_zero,
    output logic [1:0]  out_op,
    output logic        busy
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {IDLE, EXEC, ROT2} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] data_q, data_d;
    logic [3:0]  shamt_q, shamt_d;
    logic [15:0] temp_q, temp_d;
    logic        outValid_q, outValid_d;
    logic [15:0] outData_q, outData_d;
    logic        outZero_q, outZero_d;
    logic [1:0]  outOp_q, outOp_d;

    logic [15:0] sllOut, srlOut, sraOut, srlRotOut;
    logic [3:0]  rotBackAmt;
    logic        loadResult;
    logic [15:0] result;

    // Second rotate pass shifts right by 16-shamt; in 4 bits that is -shamt.
    assign rotBackAmt = 4'(-shamt_q);

    Sll16 uSll    (.a_i(data_q), .shamt_i(shamt_q),    .y_o(sllOut));
    Srl16 uSrl    (.a_i(data_q), .shamt_i(shamt_q),    .y_o(srlOut));
    Sra16 uSra    (.a_i(data_q), .shamt_i(shamt_q),    .y_o(sraOut));
    Srl16 uSrlRot (.a_i(data_q), .shamt_i(rotBackAmt), .y_o(srlRotOut));

    assign in_ready  = (state_q == IDLE) && (!outValid_q || out_ready);
    assign busy      = (state_q != IDLE);
    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_zero  = outZero_q;
    assign out_op    = outOp_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        shamt_d    = shamt_q;
        temp_d     = temp_q;
        outValid_d = outValid_q && !out_ready;
        outData_d  = outData_q;
        outZero_d  = outZero_q;
        outOp_d    = outOp_q;
        loadResult = 1'b0;
        result     = '0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    op_d    = in_op;
                    data_d  = in_data;
                    shamt_d = in_shamt;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = IDLE;
                case (op_q)
                    OP_SLL: begin loadResult = 1'b1; result = sllOut; end
                    OP_SRL: begin loadResult = 1'b1; result = srlOut; end
                    OP_SRA: begin loadResult = 1'b1; result = sraOut; end
                    OP_ROL: begin
                        if (shamt_q == 4'd0) begin
                            loadResult = 1'b1;
                            result     = data_q;
                        end else begin
                            temp_d  = sllOut;
                            state_d = ROT2;
                        end
                    end
                    default: ;
                endcase
            end
            ROT2: begin
                loadResult = 1'b1;
                result     = temp_q | srlRotOut;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (loadResult) begin
            outValid_d = 1'b1;
            outData_d  = result;
            outZero_d  = (result == 16'd0);
            outOp_d    = op_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            data_q     <= '0;
            shamt_q    <= '0;
            temp_q     <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outZero_q  <= 1'b1;
            outOp_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            shamt_q    <= shamt_d;
            temp_q     <= temp_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outZero_q  <= outZero_d;
            outOp_q    <= outOp_d;
        end
    end
endmodule
